// File: rtl/sdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdu_pkg
//  Description : Shared definitions for the serial debug unit run controller:
//                command op codes, completion codes, FSM state encoding and
//                a saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdu_pkg;

    localparam int BP_NUM_MAX = 8;

    // Command op codes from the SDU decoder (5..7 reserved)
    localparam logic [2:0] c_op_halt   = 3'd0;
    localparam logic [2:0] c_op_step   = 3'd1;
    localparam logic [2:0] c_op_run    = 3'd2;
    localparam logic [2:0] c_op_set_bp = 3'd3;
    localparam logic [2:0] c_op_clr_bp = 3'd4;

    // Completion codes reported with done_valid
    localparam logic [1:0] c_done_stepped = 2'd0;
    localparam logic [1:0] c_done_bp_hit  = 2'd1;
    localparam logic [1:0] c_done_halted  = 2'd2;
    localparam logic [1:0] c_done_cfg_ack = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP_HI = 3'd1,
        S_STEP_LO = 3'd2,
        S_RUN_HI  = 3'd3,
        S_RUN_LO  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdu_bp_match.sv
`default_nettype none
// ============================================================================
//  Module      : sdu_bp_match
//  Description : Combinational breakpoint comparator bank. Flags a hit when
//                any enabled slot address equals the CPU next PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdu_bp_match #(
    parameter int BP_NUM = 2,
    parameter int PC_W   = 32
) (
    input  logic [BP_NUM-1:0]           i_bp_en,
    input  logic [BP_NUM-1:0][PC_W-1:0] i_bp_addr,
    input  logic [PC_W-1:0]             i_npc,
    output logic                        o_hit
);

    logic [BP_NUM-1:0] w_slot_hit;

    // One equality comparator per slot, masked by its enable
    generate
        for (genvar gi = 0; gi < BP_NUM; gi++) begin : g_cmp
            assign w_slot_hit[gi] = i_bp_en[gi] && (i_bp_addr[gi] == i_npc);
        end
    endgenerate

    assign o_hit = |w_slot_hit;

endmodule
`default_nettype wire

// File: rtl/sdu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdu_run_ctrl
//  Description : SDU execution controller. Converts HALT/STEP/RUN/SET_BP/
//                CLR_BP commands into a registered CPU clock pulse train,
//                stops free-run on a breakpoint match and reports completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdu_run_ctrl
    import sdu_pkg::*;
#(
    parameter int BP_NUM = 2,
    parameter int PC_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [2:0]      cmd_idx,
    input  logic [PC_W-1:0] cmd_arg,
    input  logic [PC_W-1:0] npc,
    output logic            clk_cpu,
    output logic            busy,
    output logic            done_valid,
    output logic [1:0]      done_code,
    output logic [31:0]     step_cnt
);

    localparam int c_idx_w = (BP_NUM > 1) ? $clog2(BP_NUM) : 1;

    state_t                      r_state;
    logic                        r_clk_cpu;
    logic                        r_busy;
    logic                        r_done_valid;
    logic [1:0]                  r_done_code;
    logic [31:0]                 r_step_cnt;
    logic [BP_NUM-1:0]           r_bp_en;
    logic [BP_NUM-1:0][PC_W-1:0] r_bp_addr;
    logic                        r_halt_pend;
    logic                        r_first_lo;

    logic                        w_cmd_ready;
    logic                        w_accept;
    logic                        w_halt_req;
    logic                        w_hit;
    logic [c_idx_w-1:0]          w_idx;
    logic                        w_idx_ok;
    logic                        w_unused_idx;

    // Slot index uses only the low bits; out-of-range slots are dropped
    assign w_idx        = (BP_NUM > 1) ? cmd_idx[c_idx_w-1:0] : '0;
    assign w_idx_ok     = (int'(w_idx) < BP_NUM);
    assign w_unused_idx = ^cmd_idx;

    sdu_bp_match #(
        .BP_NUM (BP_NUM),
        .PC_W   (PC_W)
    ) u_bp_match (
        .i_bp_en   (r_bp_en),
        .i_bp_addr (r_bp_addr),
        .i_npc     (npc),
        .o_hit     (w_hit)
    );

    // Ready depends only on state, and on op while running (only HALT enters)
    always_comb begin
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE:             w_cmd_ready = 1'b1;
            S_RUN_HI, S_RUN_LO: w_cmd_ready = (cmd_op == c_op_halt);
            default:            w_cmd_ready = 1'b0;
        endcase
    end

    assign w_accept   = cmd_valid && w_cmd_ready;
    assign w_halt_req = w_accept && (cmd_op == c_op_halt);

    // Control FSM with registered CPU clock, busy and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clk_cpu    <= 1'b0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_code  <= 2'd0;
            r_step_cnt   <= 32'd0;
            r_bp_en      <= '0;
            r_bp_addr    <= '0;
            r_halt_pend  <= 1'b0;
            r_first_lo   <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            c_op_step: begin
                                r_state    <= S_STEP_HI;
                                r_clk_cpu  <= 1'b1;
                                r_busy     <= 1'b1;
                                r_step_cnt <= 32'd1;
                            end
                            c_op_run: begin
                                r_state     <= S_RUN_HI;
                                r_clk_cpu   <= 1'b1;
                                r_busy      <= 1'b1;
                                r_step_cnt  <= 32'd1;
                                r_halt_pend <= 1'b0;
                                r_first_lo  <= 1'b1;
                            end
                            c_op_set_bp: begin
                                if (w_idx_ok) begin
                                    r_bp_addr[w_idx] <= cmd_arg;
                                    r_bp_en[w_idx]   <= 1'b1;
                                end
                                r_state      <= S_DONE;
                                r_done_valid <= 1'b1;
                                r_done_code  <= c_done_cfg_ack;
                            end
                            c_op_clr_bp: begin
                                if (w_idx_ok) begin
                                    r_bp_en[w_idx] <= 1'b0;
                                end
                                r_state      <= S_DONE;
                                r_done_valid <= 1'b1;
                                r_done_code  <= c_done_cfg_ack;
                            end
                            c_op_halt: begin
                                r_state      <= S_DONE;
                                r_done_valid <= 1'b1;
                                r_done_code  <= c_done_halted;
                            end
                            default: begin
                                // reserved op: swallowed without a report
                            end
                        endcase
                    end
                end
                S_STEP_HI: begin
                    r_state   <= S_STEP_LO;
                    r_clk_cpu <= 1'b0;
                end
                S_STEP_LO: begin
                    r_state      <= S_DONE;
                    r_busy       <= 1'b0;
                    r_done_valid <= 1'b1;
                    r_done_code  <= c_done_stepped;
                end
                S_RUN_HI: begin
                    // a HALT here must not cut the pulse short; remember it
                    r_state   <= S_RUN_LO;
                    r_clk_cpu <= 1'b0;
                    if (w_halt_req) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                S_RUN_LO: begin
                    r_first_lo <= 1'b0;
                    if (r_halt_pend || w_halt_req) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_done_code  <= c_done_halted;
                    end else if (!r_first_lo && w_hit) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_done_code  <= c_done_bp_hit;
                    end else begin
                        r_state    <= S_RUN_HI;
                        r_clk_cpu  <= 1'b1;
                        r_step_cnt <= sat_inc32(r_step_cnt);
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_halt_pend <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cpu <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign clk_cpu    = r_clk_cpu;
    assign busy       = r_busy;
    assign done_valid = r_done_valid;
    assign done_code  = r_done_code;
    assign step_cnt   = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdu_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdu_run_ctrl
//  Description : Directed self-checking bench for sdu_run_ctrl with a small
//                table-driven CPU model that advances npc on each clk_cpu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdu_run_ctrl;
    import sdu_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op    = 3'd0;
    logic [2:0]  cmd_idx   = 3'd0;
    logic [31:0] cmd_arg   = 32'd0;
    logic [31:0] npc       = 32'd0;
    logic        clk_cpu;
    logic        busy;
    logic        done_valid;
    logic [1:0]  done_code;
    logic [31:0] step_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    int          pulses  = 0;
    int          npc_i   = 0;
    logic [31:0] npc_tab [0:15];

    sdu_run_ctrl #(.BP_NUM(2), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_arg    (cmd_arg),
        .npc        (npc),
        .clk_cpu    (clk_cpu),
        .busy       (busy),
        .done_valid (done_valid),
        .done_code  (done_code),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    // CPU model: each clk_cpu rising edge retires one step and moves npc
    always @(posedge clk_cpu) begin
        pulses = pulses + 1;
        npc_i  = npc_i + 1;
        npc    = npc_tab[npc_i % 16];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one command for a cycle; returns at the negedge after acceptance
    task automatic send(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic load_linear();
        for (int k = 0; k < 16; k++) npc_tab[k] = 32'(4 * k);
        npc_i  = 0;
        pulses = 0;
        npc    = npc_tab[0];
    endtask

    task automatic cfg(input string tag, input logic [2:0] op, input logic [31:0] arg);
        send(op, 3'd0, arg);
        check({tag, "_ack_valid"}, done_valid, 1'b1);
        check({tag, "_ack_code"}, done_code, c_done_cfg_ack);
        @(negedge clk);
    endtask

    // Wait for the given pulse count in the given clk_cpu phase, no early done
    task automatic wait_phase(input string tag, input int n, input logic hi);
        logic found = 1'b0;
        logic early = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (done_valid) early = 1'b1;
            if (pulses == n && clk_cpu == hi) found = 1'b1;
        end
        check({tag, "_reached"}, found, 1'b1);
        check({tag, "_no_early_done"}, early, 1'b0);
    endtask

    task automatic run_until_done(input string tag, input logic [1:0] code,
                                  input int exp_pulses, input logic [31:0] exp_cnt);
        logic found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (done_valid) found = 1'b1;
        end
        check({tag, "_done_seen"}, found, 1'b1);
        check({tag, "_code"}, done_code, code);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_step_cnt"}, step_cnt, exp_cnt);
    endtask

    // Issue HALT in the current cycle; returns at the following negedge
    task automatic halt_now(input string tag);
        cmd_valid = 1'b1;
        cmd_op    = c_op_halt;
        #1;
        check({tag, "_halt_ready"}, cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        load_linear();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_clk_cpu", clk_cpu, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_done_code", done_code, 2'd0);
        check("rst_step_cnt", step_cnt, 32'd0);
        check("rst_ready", cmd_ready, 1'b1);
        pulses = 0;

        // Single step: high at T+1, low at T+2, done at T+3, ready at T+4
        send(c_op_step, 3'd0, 32'd0);
        check("step_hi", clk_cpu, 1'b1);
        check("step_busy", busy, 1'b1);
        check("step_hi_ready", cmd_ready, 1'b0);
        @(negedge clk);
        check("step_lo", clk_cpu, 1'b0);
        check("step_lo_done", done_valid, 1'b0);
        @(negedge clk);
        check("step_done", done_valid, 1'b1);
        check("step_code", done_code, c_done_stepped);
        check("step_cnt", step_cnt, 32'd1);
        @(negedge clk);
        check("step_done_gone", done_valid, 1'b0);
        check("step_idle_ready", cmd_ready, 1'b1);
        check("step_pulses", pulses, 1);

        // Breakpoint at 0x10 with npc 0,4,8,C,10 -> stops after 4 pulses
        cfg("set0", c_op_set_bp, 32'h10);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        run_until_done("bp_hit", c_done_bp_hit, 4, 32'd4);
        repeat (4) @(negedge clk);
        check("bp_hit_no_extra", pulses, 4);
        check("bp_hit_clk_low", clk_cpu, 1'b0);

        // First check skipped: npc 0x10 after pulse 1, again after pulse 5
        npc_tab[0] = 32'h10; npc_tab[1] = 32'h10; npc_tab[2] = 32'h14;
        npc_tab[3] = 32'h18; npc_tab[4] = 32'h1C; npc_tab[5] = 32'h10;
        for (int k = 6; k < 16; k++) npc_tab[k] = 32'h100;
        npc_i = 0; pulses = 0; npc = npc_tab[0];
        send(c_op_run, 3'd0, 32'd0);
        run_until_done("bp_skip", c_done_bp_hit, 5, 32'd5);
        @(negedge clk);

        // No breakpoints, HALT in RUN_HI: pulse completes, then HALTED
        cfg("clr0a", c_op_clr_bp, 32'd0);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        cmd_op = c_op_step;
        #1 check("run_ready_step", cmd_ready, 1'b0);
        cmd_op = c_op_halt;
        #1 check("run_ready_halt", cmd_ready, 1'b1);
        wait_phase("halt_hi", 3, 1'b1);
        halt_now("halt_hi");
        check("halt_hi_lo_phase", clk_cpu, 1'b0);
        check("halt_hi_not_yet", done_valid, 1'b0);
        @(negedge clk);
        check("halt_hi_done", done_valid, 1'b1);
        check("halt_hi_code", done_code, c_done_halted);
        check("halt_hi_cnt", step_cnt, 32'd3);
        repeat (5) @(negedge clk);
        check("halt_hi_no_more", pulses, 3);
        check("halt_hi_clk_low", clk_cpu, 1'b0);

        // HALT and breakpoint match in the same RUN_LO: HALT wins
        cfg("set0b", c_op_set_bp, 32'h10);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        wait_phase("halt_bp", 4, 1'b0);
        halt_now("halt_bp");
        check("halt_bp_done", done_valid, 1'b1);
        check("halt_bp_code", done_code, c_done_halted);
        check("halt_bp_pulses", pulses, 4);
        @(negedge clk);

        // Cleared breakpoint no longer stops the run
        cfg("clr0b", c_op_clr_bp, 32'd0);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        wait_phase("clr_run", 6, 1'b0);
        halt_now("clr_run");
        check("clr_run_code", done_code, c_done_halted);
        check("clr_run_done", done_valid, 1'b1);
        @(negedge clk);

        // Reset while clk_cpu is high: immediate drop, table cleared, no done
        cfg("set0c", c_op_set_bp, 32'h10);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        wait_phase("mid_rst", 2, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_clk_cpu", clk_cpu, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cnt", step_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (done_valid) seen = 1'b1;
            end
            check("mid_rst_no_done", seen, 1'b0);
        end
        check("mid_rst_ready", cmd_ready, 1'b1);
        load_linear();
        send(c_op_run, 3'd0, 32'd0);
        wait_phase("post_rst", 6, 1'b0);
        halt_now("post_rst");
        check("post_rst_code", done_code, c_done_halted);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdu_run_ctrl.md
# sdu_run_ctrl

Execution controller for the serial debug unit: it turns decoded debug commands (halt, single-step, run, set/clear breakpoint) into a gated CPU clock pulse train on `clk_cpu`. The block sits between the SDU command decoder and the CPU under debug. During free-run it compares the CPU's `npc` against a small breakpoint table and stops the CPU on a match. A one-cycle completion report goes back to the SDU so it can print status over the UART.

## Interface
Parameters:
- `BP_NUM`, default 2: number of breakpoint slots (1..8).
- `PC_W`, default 32: PC / breakpoint address width.

Ports:
- `clk`  in  1  system clock; `clk_cpu` is derived from it.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command strobe from the SDU decoder.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  0 HALT, 1 STEP, 2 RUN, 3 SET_BP, 4 CLR_BP; 5–7 reserved.
- `cmd_idx`  in  3  breakpoint slot for SET_BP/CLR_BP; only the low `$clog2(BP_NUM)` bits are used.
- `cmd_arg`  in  `PC_W`  breakpoint address for SET_BP.
- `npc`  in  `PC_W`  next PC from the CPU, valid while `clk_cpu` is low.
- `clk_cpu`  out  1  registered CPU clock; exactly one high cycle per CPU step.
- `busy`  out  1  high while stepping or running.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_code`  out  2  0 STEPPED, 1 BP_HIT, 2 HALTED, 3 CFG_ACK; valid with `done_valid`.
- `step_cnt`  out  32  CPU pulses since the last STEP/RUN was accepted.

## Operation
- States:
  - IDLE
  - STEP_HI, STEP_LO
  - RUN_HI, RUN_LO
  - DONE
- IDLE, `cmd_ready`=1:
  - STEP → STEP_HI.
  - RUN → RUN_HI.
  - SET_BP → write `bp_addr[idx]`=`cmd_arg`, set `bp_en[idx]`; go to DONE with CFG_ACK.
  - CLR_BP → clear `bp_en[idx]`; go to DONE with CFG_ACK.
  - HALT → DONE with HALTED (no pulse).
  - Reserved ops are accepted and ignored; no done pulse.
- STEP and RUN both clear `step_cnt` on acceptance.
- STEP_HI → STEP_LO → DONE, with code STEPPED.
- RUN_HI → RUN_LO. In RUN_LO:
  - If a HALT is accepted this cycle or earlier in the run → DONE, HALTED.
  - Else if any enabled `bp_addr[i]==npc` → DONE, BP_HIT.
  - Else → RUN_HI.
- HALT takes priority over BP_HIT in the same RUN_LO cycle.
- Breakpoint check is suppressed on the first RUN_LO of a run, so RUN from a breakpoint address advances past it.
- `cmd_ready` in RUN_HI/RUN_LO is 1 only when `cmd_op`==HALT; a HALT accepted in RUN_HI is latched (`halt_pend`) and acted on in the next RUN_LO. A started pulse is never truncated.
- `cmd_ready`=0 in STEP_HI, STEP_LO and DONE.
- DONE → IDLE after one cycle; `done_valid`=1 only in DONE.
- `step_cnt` increments on entry to each *_HI state and saturates at 0xFFFF_FFFF.
- Set/clear to the same slot: the last accepted command wins. SET_BP to a slot that is already enabled overwrites its address.

## Timing
- Reset values:
  - state IDLE, `clk_cpu`=0, `busy`=0, `done_valid`=0, `done_code`=0
  - `step_cnt`=0, all `bp_en`=0, `bp_addr`=0, `halt_pend`=0
  - `cmd_ready`=1 (combinational from state)
- `clk_cpu`, `busy`, `done_*` are registered; `clk_cpu`=1 exactly in *_HI states.
- STEP accepted at cycle T:
  - `clk_cpu` high at T+1, low at T+2.
  - `done_valid` at T+3; IDLE and ready at T+4.
- RUN: period of 2 clk per CPU step. A breakpoint match sampled in RUN_LO at cycle N gives `done_valid` at N+1; no further `clk_cpu` pulse occurs.
- HALT accepted in RUN_HI at N: the pulse completes, RUN_LO at N+1, `done_valid` (HALTED) at N+2.
- SET_BP/CLR_BP accepted at T: table updated at T+1, CFG_ACK at T+1.
- `rst` mid-run: `clk_cpu` drops asynchronously, the breakpoint table is cleared, and no done pulse is produced.

## Structure
- Shared package `sdu_pkg`: op codes, done codes, `state_t` enum, `BP_NUM_MAX`=8.
- One sub-module, `sdu_bp_match`: a combinational array of `BP_NUM` comparators with enable masking, outputting `hit`.

## Test plan
- Reset, then STEP → exactly one `clk_cpu` high cycle at T+1, `done_code`=0 at T+3, `step_cnt`=1.
- SET_BP idx0=0x0000_0010, RUN with the CPU model stepping `npc` by 4 from 0 → 4 pulses, BP_HIT, `step_cnt`=4.
- RUN with `npc` already 0x10 (bp0 enabled), next `npc`=0x10 again after 4 steps → the first check is skipped and the run stops only at the later match.
- RUN with no breakpoints, HALT asserted during RUN_HI → the pulse completes, HALTED, and `clk_cpu` stays 0 afterwards.
- HALT and breakpoint match in the same RUN_LO → `done_code`=2; CLR_BP idx0 then RUN → no BP_HIT.
- Assert `rst` while `clk_cpu`=1 → `clk_cpu`=0 immediately, `bp_en`=0, `done_valid` never pulses.
